// File: rtl/fetch_stage_if.sv
// Y86-64 fetch stage bus: pipeline-control and redirect inputs, the
// instruction-memory load port, and the registered D-stage outputs.
//   master: pipeline control / loader side (drives controls, sees D outputs)
//   slave : fetch stage side
interface fetch_stage_if #(
  parameter int W = 64
);
  logic         F_stall;
  logic         D_stall;
  logic         D_bubble;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valA;
  logic [3:0]   W_icode;
  logic [W-1:0] W_valM;
  logic         imem_we;
  logic [W-1:0] imem_waddr;
  logic [7:0]   imem_wdata;
  logic [W-1:0] f_pc;
  logic [2:0]   D_stat;
  logic [3:0]   D_icode;
  logic [3:0]   D_ifun;
  logic [3:0]   D_rA;
  logic [3:0]   D_rB;
  logic [W-1:0] D_valC;
  logic [W-1:0] D_valP;
  logic [W-1:0] F_predPC;

  modport master (
    output F_stall, D_stall, D_bubble, M_icode, M_Cnd, M_valA, W_icode, W_valM,
           imem_we, imem_waddr, imem_wdata,
    input  f_pc, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, F_predPC
  );

  modport slave (
    input  F_stall, D_stall, D_bubble, M_icode, M_Cnd, M_valA, W_icode, W_valM,
           imem_we, imem_waddr, imem_wdata,
    output f_pc, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, F_predPC
  );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage with F (predicted PC) and D pipeline registers.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : stall/bubble controls, M/W redirects (mispredicted jXX,
//                  ret), byte-wide instruction memory write port, combinational
//                  f_pc, registered D_stat/D_icode/D_ifun/D_rA/D_rB/D_valC/
//                  D_valP and F_predPC.
module fetch_stage #(
  parameter int MEM_BYTES = 4096,
  parameter int W         = 64
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    I_HALT = 4'h0, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
    I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
  } icode_e;

  typedef enum logic [2:0] {
    S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4
  } stat_e;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [W-1:0] valc;
    logic [W-1:0] valp;
  } dreg_t;

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  // Addresses are compared in a widened space so f_pc + offset never wraps.
  localparam int XW = W + 4;
  localparam logic [XW-1:0] MEM_LIMIT = XW'(MEM_BYTES);
  localparam dreg_t BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                               ra: 4'hF, rb: 4'hF, valc: '0, valp: '0};

  logic [7:0]   mem [MEM_BYTES];
  logic [7:0]   ibyte [10];
  logic [W-1:0] pc_sel;
  logic [3:0]   raw_icode;
  logic         instr_valid, need_regids, need_valc, imem_error;
  logic [3:0]   len;
  logic [XW-1:0] last_addr;
  logic [63:0]  valc64;
  logic [W-1:0] valc, valp, predpc, predpc_q;
  dreg_t        fetched, d_q;

  always_ff @(posedge clock) begin
    if (bus.imem_we && ({4'b0, bus.imem_waddr} < MEM_LIMIT))
      mem[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
  end

  always_comb begin
    pc_sel = predpc_q;
    if (bus.M_icode == I_JXX && !bus.M_Cnd)
      pc_sel = bus.M_valA;
    else if (bus.W_icode == I_RET)
      pc_sel = bus.W_valM;
  end

  // Out-of-range bytes read as zero so nothing beyond the array is touched.
  always_comb begin
    logic [XW-1:0] ea;
    ea = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      ea = {4'b0, pc_sel} + XW'(i);
      ibyte[i] = (ea < MEM_LIMIT) ? mem[ea[AW-1:0]] : 8'h00;
    end
  end

  always_comb begin
    raw_icode   = ibyte[0][7:4];
    instr_valid = (raw_icode <= I_POPQ);
    need_regids = raw_icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                    I_OPQ, I_PUSHQ, I_POPQ};
    need_valc   = raw_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    len         = 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valc ? 4'd8 : 4'd0);
    last_addr   = {4'b0, pc_sel} + XW'(len) - XW'(1);
    imem_error  = (last_addr >= MEM_LIMIT);

    valc64 = '0;
    for (int unsigned j = 0; j < 8; j++)
      valc64[8*j +: 8] = need_regids ? ibyte[j+2] : ibyte[j+1];
    valc = need_valc ? W'(valc64) : '0;
    valp = pc_sel + W'(len);

    fetched       = BUBBLE;
    fetched.valp  = valp;
    if (imem_error) begin
      fetched.stat  = S_ADR;
    end else begin
      fetched.icode = raw_icode;
      fetched.ifun  = ibyte[0][3:0];
      fetched.valc  = valc;
      if (need_regids) begin
        fetched.ra = ibyte[1][7:4];
        fetched.rb = ibyte[1][3:0];
      end
      if (!instr_valid)
        fetched.stat = S_INS;
      else if (raw_icode == I_HALT)
        fetched.stat = S_HLT;
      else
        fetched.stat = S_AOK;
    end

    predpc = (fetched.icode == I_JXX || fetched.icode == I_CALL) ? fetched.valc : valp;
  end

  always_ff @(posedge clock) begin
    if (reset)
      predpc_q <= '0;
    else if (!bus.F_stall)
      predpc_q <= predpc;
  end

  // Stall has priority over bubble.
  always_ff @(posedge clock) begin
    if (reset)
      d_q <= BUBBLE;
    else if (!bus.D_stall)
      d_q <= bus.D_bubble ? BUBBLE : fetched;
  end

  assign bus.f_pc     = pc_sel;
  assign bus.F_predPC = predpc_q;
  assign bus.D_stat   = d_q.stat;
  assign bus.D_icode  = d_q.icode;
  assign bus.D_ifun   = d_q.ifun;
  assign bus.D_rA     = d_q.ra;
  assign bus.D_rB     = d_q.rb;
  assign bus.D_valC   = d_q.valc;
  assign bus.D_valP   = d_q.valp;

endmodule
